// File: rtl/branch_predictor.sv
// Branch predictor: a table of two-bit saturating counters plus a queue of
// unresolved predictions that drives a backup-PC FIFO and recovers on mispredict.
module branch_predictor #(
  parameter int DEPTH    = 4,
  parameter int BHT_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [10:0] fetch_pc,
  input  logic        is_branch,
  input  logic [10:0] branch_target,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  output logic [10:0] next_pc,
  output logic        pred_taken,
  output logic        stall,
  output logic        bk_enable,
  output logic        bk_select,
  output logic        bk_push,
  output logic        bk_pop,
  output logic        bk_clear,
  output logic        mispredict,
  output logic        resolve_err
);

  localparam int ENTRIES = 1 << BHT_BITS;
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [BHT_BITS-1:0] bht_index;
    logic                pred_taken;
  } pend_t;

  logic [1:0] bht_q [ENTRIES];
  logic [1:0] bht_d [ENTRIES];
  pend_t      pend_q [DEPTH];
  pend_t      pend_d [DEPTH];

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;
  logic resolve_err_q, resolve_err_d;
  logic bk_clear_q, bk_clear_d;

  logic                branch_fetch;
  logic [BHT_BITS-1:0] fetch_index;
  pend_t               head_entry;
  logic                queue_full;
  logic                queue_empty;
  logic                accept;
  logic                do_resolve;

  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    else       return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

  // Prediction reads the registered table, so a same-cycle update to the
  // same index is seen only by the following fetch.
  always_comb begin
    branch_fetch = fetch_valid & is_branch;
    fetch_index  = fetch_pc[BHT_BITS-1:0];
    head_entry   = pend_q[head_q];
    queue_full   = (count_q == cnt_t'(DEPTH));
    queue_empty  = (count_q == '0);

    pred_taken = branch_fetch & bht_q[fetch_index][1];
    next_pc    = pred_taken ? branch_target : fetch_pc + 11'd1;
    bk_enable  = branch_fetch;
    bk_select  = ~pred_taken;
    stall      = branch_fetch & queue_full;

    do_resolve = resolve_valid & ~queue_empty;
    mispredict = do_resolve & (resolve_taken != head_entry.pred_taken);
    accept     = branch_fetch & ~queue_full & ~mispredict;
    bk_push    = accept;
    bk_pop     = do_resolve;

    bk_clear    = bk_clear_q;
    resolve_err = resolve_err_q;
  end

  // NOTE: every variable gets its default before any conditional update so
  // this block stays purely combinational and no latch is inferred.
  always_comb begin
    bht_d         = bht_q;
    pend_d        = pend_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    resolve_err_d = resolve_err_q | (resolve_valid & queue_empty);
    bk_clear_d    = mispredict;

    if (do_resolve) begin
      bht_d[head_entry.bht_index] = sat_update(bht_q[head_entry.bht_index], resolve_taken);
      head_d = next_ptr(head_q);
    end

    if (accept) begin
      pend_d[tail_q] = '{bht_index: fetch_index, pred_taken: pred_taken};
      tail_d = next_ptr(tail_q);
    end

    case ({accept, do_resolve})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase

    // Recovery discards every pending prediction; the backup FIFO is cleared
    // by the bk_clear pulse on the following cycle.
    if (mispredict) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= 2'b01;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      resolve_err_q <= 1'b0;
      bk_clear_q    <= 1'b0;
    end else begin
      bht_q         <= bht_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      resolve_err_q <= resolve_err_d;
      bk_clear_q    <= bk_clear_d;
    end
  end

  // NOTE: the pending-queue payload is deliberately not reset; an entry is
  // only read after being written, since count gates every pop.
  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: the driver queues expected outputs per
// cycle, and a monitor on the falling edge pops and compares them.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [10:0] fetch_pc;
  logic        is_branch;
  logic [10:0] branch_target;
  logic        resolve_valid;
  logic        resolve_taken;
  logic [10:0] next_pc;
  logic        pred_taken;
  logic        stall;
  logic        bk_enable;
  logic        bk_select;
  logic        bk_push;
  logic        bk_pop;
  logic        bk_clear;
  logic        mispredict;
  logic        resolve_err;

  branch_predictor #(.DEPTH(4), .BHT_BITS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc),
    .is_branch     (is_branch),
    .branch_target (branch_target),
    .resolve_valid (resolve_valid),
    .resolve_taken (resolve_taken),
    .next_pc       (next_pc),
    .pred_taken    (pred_taken),
    .stall         (stall),
    .bk_enable     (bk_enable),
    .bk_select     (bk_select),
    .bk_push       (bk_push),
    .bk_pop        (bk_pop),
    .bk_clear      (bk_clear),
    .mispredict    (mispredict),
    .resolve_err   (resolve_err)
  );

  always #5 clk = ~clk;

  localparam int D = -1;  // field not compared

  // Packed output order: next_pc, pred_taken, stall, bk_enable, bk_select,
  // bk_push, bk_pop, bk_clear, mispredict, resolve_err.
  typedef struct {
    string       name;
    logic [19:0] val;
    logic [19:0] mask;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t ev(input string n, input int npc, input int pt, input int st,
                              input int en, input int sel, input int push, input int pop,
                              input int clr, input int mp, input int re);
    exp_t e;
    int   b[9];
    e.name = n;
    e.val  = '0;
    e.mask = '0;
    if (npc >= 0) begin
      e.val[19:9]  = npc[10:0];
      e.mask[19:9] = '1;
    end
    b = '{pt, st, en, sel, push, pop, clr, mp, re};
    for (int i = 0; i < 9; i++) begin
      if (b[i] >= 0) begin
        e.val[8-i]  = b[i][0];
        e.mask[8-i] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic check(input exp_t e, input logic [19:0] act);
    checks++;
    if (((act ^ e.val) & e.mask) != 20'd0) begin
      errors++;
      $display("FAIL %s: got %h expected %h (compared bits %h)", e.name, act, e.val, e.mask);
    end
  endtask

  task automatic drive(input logic rst, input logic fv, input logic br,
                       input logic [10:0] pc, input logic [10:0] tgt,
                       input logic rv, input logic rt);
    @(posedge clk);
    #1;
    reset         = rst;
    fetch_valid   = fv;
    is_branch     = br;
    fetch_pc      = pc;
    branch_target = tgt;
    resolve_valid = rv;
    resolve_taken = rt;
  endtask

  task automatic expect_now(input exp_t e);
    sb_q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents outputs, consume what the driver queued.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      check(sb_q.pop_front(), {next_pc, pred_taken, stall, bk_enable, bk_select,
                               bk_push, bk_pop, bk_clear, mispredict, resolve_err});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; fetch_valid = 1'b0; is_branch = 1'b0; fetch_pc = '0;
    branch_target = '0; resolve_valid = 1'b0; resolve_taken = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 0);
    expect_now(ev("reset_idle", 'h001, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    drive(0, 1, 1, 'h010, 'h100, 0, 0);
    expect_now(ev("first_branch", 'h011, 0, 0, 1, 1, 1, 0, 0, 0, D));

    // Counter 0 trains upward: 01 -> 10 -> 11, then saturates.
    drive(0, 0, 0, 0, 0, 1, 1);
    expect_now(ev("resolve_mispred", D, D, D, D, D, 0, 1, 0, 1, D));
    drive(0, 1, 1, 'h000, 'h055, 0, 0);
    expect_now(ev("ctr_10_taken", 'h055, 1, 0, 1, 0, 1, 0, 1, 0, D));
    drive(0, 0, 0, 0, 0, 1, 1);
    expect_now(ev("resolve_hit", D, D, D, D, D, 0, 1, 0, 0, D));
    drive(0, 1, 1, 'h020, 'h200, 0, 0);
    expect_now(ev("idx0_taken", 'h200, 1, 0, 1, 0, 1, 0, 0, 0, D));
    drive(0, 0, 0, 0, 0, 1, 1);
    expect_now(ev("resolve_hit2", D, D, D, D, D, D, 1, D, 0, D));
    drive(0, 1, 1, 'h030, 'h123, 0, 0);
    expect_now(ev("sat_hold", 'h123, 1, D, D, 0, 1, D, D, D, D));
    drive(0, 0, 0, 0, 0, 1, 0);
    expect_now(ev("resolve_nt_mispred", D, D, D, D, D, D, 1, D, 1, D));
    drive(0, 1, 1, 'h040, 'h0AA, 0, 0);
    expect_now(ev("sat_not_wrapped", 'h0AA, 1, D, D, D, 1, D, 1, D, D));
    drive(0, 0, 0, 0, 0, 1, 0);
    expect_now(ev("resolve_nt2", D, D, D, D, D, D, 1, D, 1, D));

    // Fill the queue, stall on the fifth, resolve while stalled.
    drive(0, 1, 1, 'h011, 'h300, 0, 0);
    expect_now(ev("fill_0", 'h012, 0, 0, 1, 1, 1, 0, 1, 0, D));
    for (int i = 1; i < 4; i++) begin
      drive(0, 1, 1, 11'('h011 + i), 'h300, 0, 0);
      expect_now(ev($sformatf("fill_%0d", i), 'h012 + i, 0, 0, D, D, 1, D, 0, D, D));
    end
    drive(0, 1, 1, 'h015, 'h300, 0, 0);
    expect_now(ev("full_stall", 'h016, 0, 1, 1, 1, 0, 0, D, 0, D));
    drive(0, 1, 1, 'h015, 'h300, 1, 0);
    expect_now(ev("stall_with_resolve", 'h016, 0, 1, 1, D, 0, 1, D, 0, D));
    drive(0, 1, 1, 'h015, 'h300, 0, 0);
    expect_now(ev("accept_after_full", 'h016, 0, 0, 1, D, 1, 0, D, 0, D));
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      expect_now(ev($sformatf("drain_%0d", i), D, D, D, D, D, 0, 1, D, 0, D));
    end

    // Two pending not-taken, mispredict while a branch is fetched.
    drive(0, 1, 1, 'h016, 'h310, 0, 0);
    expect_now(ev("pend_a", 'h017, 0, 0, D, D, 1, D, D, D, D));
    drive(0, 1, 1, 'h017, 'h310, 0, 0);
    expect_now(ev("pend_b", 'h018, 0, 0, D, D, 1, D, D, D, D));
    drive(0, 1, 1, 'h018, 'h310, 1, 1);
    expect_now(ev("mispred_with_fetch", 'h019, 0, 0, 1, 1, 0, 1, D, 1, D));
    drive(0, 0, 0, 0, 0, 1, 1);
    expect_now(ev("clear_and_empty_resolve", D, D, D, D, D, D, 0, 1, 0, 0));

    drive(0, 1, 1, 'h7FF, 'h050, 0, 0);
    expect_now(ev("pc_wrap", 'h000, 0, 0, 1, 1, 1, 0, 0, 0, 1));
    drive(0, 1, 1, 'h001, 'h050, 0, 0);
    expect_now(ev("err_sticky", 'h002, 0, D, D, D, 1, D, D, D, 1));

    // Reset mid-queue wins over a mispredicting resolve and a fetch.
    drive(1, 1, 1, 'h006, 'h0CC, 1, 1);
    drive(0, 1, 1, 'h006, 'h0CC, 0, 0);
    expect_now(ev("post_reset_branch", 'h007, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 1, 0);
    expect_now(ev("post_reset_head", D, D, D, D, D, D, 1, D, 0, D));
    drive(0, 0, 0, 0, 0, 1, 0);
    expect_now(ev("empty_after_drain", D, D, D, D, D, D, 0, D, 0, D));

    // Same-index predict and update in one cycle uses the old counter.
    drive(0, 1, 1, 'h009, 'h0EE, 0, 0);
    expect_now(ev("same_idx_setup", 'h00A, 0, D, D, D, 1, D, D, D, 1));
    drive(0, 1, 1, 'h009, 'h0EE, 1, 1);
    expect_now(ev("pre_update_predict", 'h00A, 0, 0, D, 1, 0, 1, D, 1, D));
    drive(0, 1, 1, 'h009, 'h0EE, 0, 0);
    expect_now(ev("post_update_predict", 'h0EE, 1, D, D, 0, 1, D, 1, D, D));

    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DEPTH, default 4: maximum number of unresolved branches; SHALL match the depth of the backup-PC FIFO.
REQ-003 Parameter BHT_BITS, default 4: BHT index width, giving 2^BHT_BITS two-bit counters.
REQ-004 Ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- fetch_valid  in  1  fetch_pc is valid this cycle
- fetch_pc  in  11  PC of the current fetch
- is_branch  in  1  current fetch is a conditional branch
- branch_target  in  11  decoded target of the branch
- resolve_valid  in  1  oldest unresolved branch resolves this cycle
- resolve_taken  in  1  actual outcome of the resolving branch
- next_pc  out  11  predicted next PC
- pred_taken  out  1  prediction for the current fetch
- stall  out  1  branch cannot be accepted (queue full)
- bk_enable  out  1  backup-FIFO enable
- bk_select  out  1  backup-FIFO select; 1 = target, 0 = fall-through
- bk_push  out  1  backup-FIFO push
- bk_pop  out  1  backup-FIFO pop
- bk_clear  out  1  backup-FIFO clear
- mispredict  out  1  resolving branch was mispredicted
- resolve_err  out  1  sticky flag: resolve arrived with the queue empty

Function
REQ-005 Storage SHALL be a BHT of 2^BHT_BITS two-bit saturating counters indexed by fetch_pc[BHT_BITS-1:0], plus a DEPTH-entry pending queue (head pointer, tail pointer, count 0..DEPTH) holding {bht_index, pred_taken} per entry.
REQ-006 Prediction SHALL be combinational: pred_taken = fetch_valid & is_branch & counter[1]; it SHALL be 0 otherwise.
REQ-007 next_pc SHALL be branch_target when pred_taken = 1, else fetch_pc + 1, computed in 11 bits so that 0x7FF wraps to 0x000.
REQ-008 bk_enable SHALL equal fetch_valid & is_branch; bk_select SHALL equal ~pred_taken, so the backup FIFO stores the path not predicted.
REQ-009 accept = fetch_valid & is_branch & (count < DEPTH) & ~mispredict; bk_push SHALL equal accept.
REQ-010 On accept, the block SHALL write {index, pred_taken} at the tail at the clock edge and advance the tail modulo DEPTH.
REQ-011 stall SHALL equal fetch_valid & is_branch & (count == DEPTH).
REQ-012 stall SHALL remain asserted when a resolve occurs in the same cycle; the branch SHALL be accepted in the next cycle.
REQ-013 do_resolve = resolve_valid & (count > 0); bk_pop SHALL equal do_resolve.
REQ-014 mispredict SHALL equal do_resolve & (resolve_taken != head.pred_taken), combinationally in the resolve cycle.
REQ-015 On do_resolve, the counter at head.bht_index SHALL saturate up (max 3) if taken, else saturate down (min 0); the head SHALL advance modulo DEPTH.
REQ-016 On mispredict, the block SHALL, at the edge, set count, head and tail to 0.
REQ-017 bk_clear SHALL be a registered one-cycle pulse in the cycle after mispredict.
REQ-018 Simultaneous accept and do_resolve without mispredict SHALL leave count unchanged; with mispredict, accept is suppressed by REQ-009.
REQ-019 A resolve_valid while count == 0 SHALL cause no pop, no BHT update and no mispredict, and SHALL set resolve_err until reset.
REQ-020 A prediction and a BHT update to the same index in the same cycle SHALL predict using the pre-update counter value.

Reset
REQ-021 In any cycle with reset = 1, at the edge, the block SHALL set:
- all counters to 2'b01 (weakly not-taken)
- count, head and tail to 0
- resolve_err and bk_clear to 0
REQ-022 Reset SHALL take priority over accept, resolve and mispredict in the same cycle.
REQ-023 Combinational outputs after reset SHALL follow REQ-006 to REQ-014 with the empty queue, i.e. bk_pop = 0 and mispredict = 0.

Verification
REQ-024 Reset, then branch at fetch_pc = 0x010, target 0x100 -> pred_taken = 0, next_pc = 0x011, bk_select = 1, bk_push = 1.
REQ-025 Resolve taken twice on index 0 -> counter 01 -> 10 -> 11; next branch at 0x020 (index 0) -> pred_taken = 1, next_pc = target; third taken resolve holds counter at 11.
REQ-026 Push 4 branches without resolving -> 5th gives stall = 1, bk_push = 0; resolve in the same cycle -> stall stays 1; branch accepted the next cycle.
REQ-027 2 pending (pred 0, 0), resolve_taken = 1 with a branch fetched the same cycle -> mispredict = 1, bk_pop = 1, bk_push = 0; next cycle bk_clear = 1, count = 0.
REQ-028 resolve_valid with empty queue -> bk_pop = 0, mispredict = 0, resolve_err = 1 held until reset.
REQ-029 Branch at fetch_pc = 0x7FF predicted not-taken -> next_pc = 0x000; reset asserted mid-queue -> count = 0, counters = 01 on the next cycle.
